// File: rtl/dp_pkg.sv
// Encodings shared verbatim with the microcoded control unit: bus sources,
// ALU operations and register load masks.
package dp_pkg;

    localparam logic [7:0] SEL_DRAM = 8'd0;
    localparam logic [7:0] SEL_IRAM = 8'd1;
    localparam logic [7:0] SEL_DI   = 8'd2;
    localparam logic [7:0] SEL_RI   = 8'd3;
    localparam logic [7:0] SEL_BI   = 8'd4;
    localparam logic [7:0] SEL_S    = 8'd5;
    localparam logic [7:0] SEL_C1   = 8'd6;
    localparam logic [7:0] SEL_C2   = 8'd7;
    localparam logic [7:0] SEL_AR   = 8'd8;
    localparam logic [7:0] SEL_AC   = 8'd9;
    localparam logic [7:0] SEL_PC   = 8'd10;
    localparam logic [7:0] SEL_IR   = 8'd11;

    localparam logic [7:0] ALU_CLEAR = 8'd0;
    localparam logic [7:0] ALU_INC   = 8'd1;
    localparam logic [7:0] ALU_DEC   = 8'd2;
    localparam logic [7:0] ALU_ADD   = 8'd3;
    localparam logic [7:0] ALU_SUB   = 8'd4;
    localparam logic [7:0] ALU_MUL2  = 8'd5;
    localparam logic [7:0] ALU_MUL4  = 8'd6;
    localparam logic [7:0] ALU_DIV16 = 8'd7;
    localparam logic [7:0] ALU_LOAD  = 8'd8;
    localparam logic [7:0] ALU_NOP   = 8'd9;

    localparam logic [8:0] REG_IR = 9'h001;
    localparam logic [8:0] REG_DI = 9'h002;
    localparam logic [8:0] REG_RI = 9'h004;
    localparam logic [8:0] REG_BI = 9'h008;
    localparam logic [8:0] REG_S  = 9'h010;
    localparam logic [8:0] REG_C1 = 9'h020;
    localparam logic [8:0] REG_C2 = 9'h040;
    localparam logic [8:0] REG_AR = 9'h080;
    localparam logic [8:0] REG_PC = 9'h100;

    typedef struct packed {
        logic       pc_inc;
        logic [7:0] alu_sel;
        logic [7:0] bus_sel;
        logic [8:0] reg_sel;
    } ctrl_word_t;

endpackage

// File: rtl/dp_alu.sv
// Accumulator ALU: next AC value plus carry/borrow and its write enable.
// Purely combinational; the caller decides whether carry is stored.
module dp_alu
    import dp_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] ac,
    input  logic [DATA_W-1:0] bus,
    input  logic [7:0]        alu_sel,
    output logic [DATA_W-1:0] next_ac,
    output logic              next_carry,
    output logic              carry_we
);

    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    always_comb begin
        next_ac    = ac;
        next_carry = 1'b0;
        carry_we   = 1'b0;
        case (alu_sel)
            ALU_CLEAR: next_ac = '0;
            ALU_INC: begin
                {next_carry, next_ac} = {1'b0, ac} + {1'b0, ONE};
                carry_we = 1'b1;
            end
            ALU_DEC: begin
                next_ac    = ac - ONE;
                next_carry = (ac == '0);
                carry_we   = 1'b1;
            end
            ALU_ADD: begin
                {next_carry, next_ac} = {1'b0, ac} + {1'b0, bus};
                carry_we = 1'b1;
            end
            ALU_SUB: begin
                next_ac    = ac - bus;
                next_carry = (ac < bus);
                carry_we   = 1'b1;
            end
            // Shifts report the last bit to fall off the top.
            ALU_MUL2: begin
                next_ac    = {ac[DATA_W-2:0], 1'b0};
                next_carry = ac[DATA_W-1];
                carry_we   = 1'b1;
            end
            ALU_MUL4: begin
                next_ac    = {ac[DATA_W-3:0], 2'b00};
                next_carry = ac[DATA_W-2];
                carry_we   = 1'b1;
            end
            ALU_DIV16: begin
                next_ac    = {4'b0000, ac[DATA_W-1:4]};
                next_carry = 1'b0;
                carry_we   = 1'b1;
            end
            ALU_LOAD: next_ac = bus;
            default:  next_ac = ac;
        endcase
    end

endmodule

// File: rtl/datapath_core.sv
// Register/bus/ALU datapath driven by the control unit's control word.
// Optional carry register enabled by defining DP_CARRY_EN.
module datapath_core
    import dp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_inc,
    input  logic [7:0]        alu_sel,
    input  logic [7:0]        bus_sel,
    input  logic [8:0]        reg_sel,
    input  logic [DATA_W-1:0] iram_rdata,
    input  logic [DATA_W-1:0] dram_rdata,
    output logic [ADDR_W-1:0] iram_addr,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [DATA_W-1:0] dram_wdata,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] ac,
    output logic              z,
    output logic              carry
);

    logic [DATA_W-1:0] ir_q, di_q, ri_q, bi_q, s_q, c1_q, c2_q, ar_q, ac_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] next_ac;
    logic              next_carry;
    logic              carry_we;

    always_comb begin
        case (bus_sel)
            SEL_DRAM: bus = dram_rdata;
            SEL_IRAM: bus = iram_rdata;
            SEL_DI:   bus = di_q;
            SEL_RI:   bus = ri_q;
            SEL_BI:   bus = bi_q;
            SEL_S:    bus = s_q;
            SEL_C1:   bus = c1_q;
            SEL_C2:   bus = c2_q;
            SEL_AR:   bus = ar_q;
            SEL_AC:   bus = ac_q;
            SEL_PC:   bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
            SEL_IR:   bus = ir_q;
            default:  bus = '0;
        endcase
    end

    dp_alu #(.DATA_W(DATA_W)) u_alu (
        .ac         (ac_q),
        .bus        (bus),
        .alu_sel    (alu_sel),
        .next_ac    (next_ac),
        .next_carry (next_carry),
        .carry_we   (carry_we)
    );

    // Bus is formed from pre-edge register values, so same-cycle loads read old data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ir_q <= '0;
            di_q <= '0;
            ri_q <= '0;
            bi_q <= '0;
            s_q  <= '0;
            c1_q <= '0;
            c2_q <= '0;
            ar_q <= '0;
            ac_q <= '0;
            pc_q <= '0;
        end else begin
            if (|(reg_sel & REG_IR)) ir_q <= bus;
            if (|(reg_sel & REG_DI)) di_q <= bus;
            if (|(reg_sel & REG_RI)) ri_q <= bus;
            if (|(reg_sel & REG_BI)) bi_q <= bus;
            if (|(reg_sel & REG_S))  s_q  <= bus;
            if (|(reg_sel & REG_C1)) c1_q <= bus;
            if (|(reg_sel & REG_C2)) c2_q <= bus;
            if (|(reg_sel & REG_AR)) ar_q <= bus;
            if (|(reg_sel & REG_PC)) pc_q <= bus[ADDR_W-1:0];
            else if (pc_inc)         pc_q <= pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            ac_q <= next_ac;
        end
    end

`ifdef DP_CARRY_EN
    logic carry_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            carry_q <= 1'b0;
        end else if (carry_we) begin
            carry_q <= next_carry;
        end
    end

    assign carry = carry_q;
`else
    logic unused_carry;
    assign unused_carry = next_carry | carry_we;
    assign carry        = 1'b0;
`endif

    assign iram_addr  = pc_q;
    assign dram_addr  = ar_q[ADDR_W-1:0];
    assign dram_wdata = bus;
    assign ir         = ir_q;
    assign ac         = ac_q;
    assign z          = (ac_q == '0);

endmodule

// File: tb/tb_datapath_core.sv
// Self-checking bench for datapath_core: directed scenarios plus random control
// words checked every cycle against an arithmetic model of the datapath.
module tb_datapath_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pc_inc = 1'b0;
    logic [7:0]  alu_sel = 8'd9;
    logic [7:0]  bus_sel = 8'd0;
    logic [8:0]  reg_sel = 9'd0;
    logic [31:0] iram_rdata = 32'd0;
    logic [31:0] dram_rdata = 32'd0;
    logic [7:0]  iram_addr;
    logic [7:0]  dram_addr;
    logic [31:0] dram_wdata;
    logic [31:0] ir;
    logic [31:0] ac;
    logic        z;
    logic        carry;

    datapath_core #(.DATA_W(32), .ADDR_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_inc     (pc_inc),
        .alu_sel    (alu_sel),
        .bus_sel    (bus_sel),
        .reg_sel    (reg_sel),
        .iram_rdata (iram_rdata),
        .dram_rdata (dram_rdata),
        .iram_addr  (iram_addr),
        .dram_addr  (dram_addr),
        .dram_wdata (dram_wdata),
        .ir         (ir),
        .ac         (ac),
        .z          (z),
        .carry      (carry)
    );

    always #5 clk = ~clk;

`ifdef DP_CARRY_EN
    localparam bit CARRY_ON = 1'b1;
`else
    localparam bit CARRY_ON = 1'b0;
`endif

    int n_err = 0;
    int n_chk = 0;
    bit chk_en = 1'b0;

    // Model state: m_r[0] is IR, m_r[1..7] are DI, RI, BI, S, C1, C2, AR
    // (same order as the load mask bits and bus codes 2..8).
    logic [31:0] m_r [8];
    logic [31:0] m_ac = 32'd0;
    logic [7:0]  m_pc = 8'd0;
    logic        m_c  = 1'b0;

    initial foreach (m_r[i]) m_r[i] = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_bus();
        if (bus_sel == 8'd0)       return dram_rdata;
        else if (bus_sel == 8'd1)  return iram_rdata;
        else if (bus_sel <= 8'd8)  return m_r[bus_sel - 8'd1];
        else if (bus_sel == 8'd9)  return m_ac;
        else if (bus_sel == 8'd10) return {24'd0, m_pc};
        else if (bus_sel == 8'd11) return m_r[0];
        return 32'd0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("iram_addr",  {24'd0, iram_addr}, {24'd0, m_pc});
            chk("dram_addr",  {24'd0, dram_addr}, {24'd0, m_r[7][7:0]});
            chk("dram_wdata", dram_wdata, m_bus());
            chk("ir",         ir, m_r[0]);
            chk("ac",         ac, m_ac);
            chk("z",          {31'd0, z}, {31'd0, m_ac == 32'd0});
            chk("carry",      {31'd0, carry}, {31'd0, CARRY_ON & m_c});
        end
    end

    task automatic drive(input logic r, input logic pi, input logic [7:0] a,
                         input logic [7:0] bs, input logic [8:0] rs,
                         input logic [31:0] ir_d, input logic [31:0] dr_d);
        reset      = r;
        pc_inc     = pi;
        alu_sel    = a;
        bus_sel    = bs;
        reg_sel    = rs;
        iram_rdata = ir_d;
        dram_rdata = dr_d;
    endtask

    // Predict the post-edge state from the current inputs, then take the edge.
    task automatic tick();
        logic [31:0] b, nac;
        logic [31:0] nr [8];
        logic [7:0]  npc;
        logic        nc;
        longint      s;
        b   = m_bus();
        nr  = m_r;
        nac = m_ac;
        npc = m_pc;
        nc  = m_c;
        if (!reset) begin
            foreach (nr[i]) nr[i] = 32'd0;
            nac = 32'd0;
            npc = 8'd0;
            nc  = 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) if (reg_sel[i]) nr[i] = b;
            if (reg_sel[8])  npc = b[7:0];
            else if (pc_inc) npc = m_pc + 8'd1;
            case (alu_sel)
                8'd0: nac = 32'd0;
                8'd1: begin nac = m_ac + 32'd1; nc = (m_ac == 32'hFFFF_FFFF); end
                8'd2: begin nac = m_ac - 32'd1; nc = (m_ac == 32'd0); end
                8'd3: begin
                    s   = longint'(m_ac) + longint'(b);
                    nac = s[31:0];
                    nc  = (s >>> 32) != 0;
                end
                8'd4: begin nac = m_ac - b; nc = (m_ac < b); end
                8'd5: begin nac = m_ac * 32'd2; nc = (m_ac >= 32'h8000_0000); end
                8'd6: begin nac = m_ac * 32'd4; nc = ((m_ac >> 30) & 32'd1) == 32'd1; end
                8'd7: begin nac = m_ac / 32'd16; nc = 1'b0; end
                8'd8: nac = b;
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        m_r  = nr;
        m_ac = nac;
        m_pc = npc;
        m_c  = nc;
    endtask

    initial begin
        // Reset held over two edges with random control applied.
        drive(1'b0, 1'b1, 8'd3, 8'd1, 9'h1FF, 32'hDEAD_BEEF, 32'h1234_5678);
        tick();
        chk_en = 1'b1;
        drive(1'b0, 1'b1, 8'd1, 8'd9, 9'h0AA, $urandom, $urandom);
        tick();
        chk("rst iram_addr", {24'd0, iram_addr}, 32'd0);
        chk("rst ac",        ac, 32'd0);
        chk("rst ir",        ir, 32'd0);
        chk("rst z",         {31'd0, z}, 32'd1);
        chk("rst carry",     {31'd0, carry}, 32'd0);

        // Load 5 then decrement to zero.
        drive(1'b1, 1'b0, 8'd8, 8'd1, 9'd0, 32'd5, 32'd0);
        tick();
        chk("load5 ac", ac, 32'd5);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 8'd2, 8'd0, 9'd0, 32'd0, 32'd0);
            tick();
            chk("dec z", {31'd0, z}, {31'd0, i == 4});
        end
        chk("dec ac", ac, 32'd0);

        // Increment wraps all-ones to zero.
        drive(1'b1, 1'b0, 8'd8, 8'd1, 9'd0, 32'hFFFF_FFFF, 32'd0);
        tick();
        drive(1'b1, 1'b0, 8'd1, 8'd0, 9'd0, 32'd0, 32'd0);
        tick();
        chk("inc wrap ac",    ac, 32'd0);
        chk("inc wrap z",     {31'd0, z}, 32'd1);
        chk("inc wrap carry", {31'd0, carry}, {31'd0, CARRY_ON});

        // Multi-register load from AC, then ADD from RI.
        drive(1'b1, 1'b0, 8'd9, 8'd1, 9'h004, 32'h10, 32'd0);
        tick();
        drive(1'b1, 1'b0, 8'd8, 8'd1, 9'd0, 32'd7, 32'd0);
        tick();
        drive(1'b1, 1'b0, 8'd9, 8'd9, 9'h022, 32'd0, 32'd0);
        tick();
        drive(1'b1, 1'b0, 8'd9, 8'd2, 9'd0, 32'd0, 32'd0);
        #1 chk("DI value", dram_wdata, 32'd7);
        drive(1'b1, 1'b0, 8'd9, 8'd6, 9'd0, 32'd0, 32'd0);
        #1 chk("C1 value", dram_wdata, 32'd7);
        drive(1'b1, 1'b0, 8'd3, 8'd3, 9'd0, 32'd0, 32'd0);
        tick();
        chk("add RI ac", ac, 32'h17);

        // Read-before-write: AC on bus during INC carries the old AC.
        drive(1'b1, 1'b0, 8'd1, 8'd9, 9'h002, 32'd0, 32'd0);
        #1 chk("rbw bus", dram_wdata, 32'h17);
        tick();
        drive(1'b1, 1'b0, 8'd9, 8'd2, 9'd0, 32'd0, 32'd0);
        #1 chk("rbw DI", dram_wdata, 32'h17);

        // PC wrap, then load beats increment.
        drive(1'b1, 1'b0, 8'd9, 8'd1, 9'h100, 32'hFF, 32'd0);
        tick();
        chk("pc load", {24'd0, iram_addr}, 32'hFF);
        drive(1'b1, 1'b1, 8'd9, 8'd0, 9'd0, 32'd0, 32'd0);
        tick();
        chk("pc wrap", {24'd0, iram_addr}, 32'd0);
        drive(1'b1, 1'b1, 8'd9, 8'd1, 9'h100, 32'h40, 32'd0);
        tick();
        chk("pc load wins", {24'd0, iram_addr}, 32'h40);

        // DIV16, then undefined bus code loads zero.
        drive(1'b1, 1'b0, 8'd8, 8'd1, 9'd0, 32'h123, 32'd0);
        tick();
        drive(1'b1, 1'b0, 8'd7, 8'd0, 9'd0, 32'd0, 32'd0);
        tick();
        chk("div16 ac", ac, 32'h12);
        drive(1'b1, 1'b0, 8'd8, 8'h0C, 9'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        chk("bad bus ac", ac, 32'd0);
        chk("bad bus z",  {31'd0, z}, 32'd1);

        // Random control words, including occasional mid-stream resets.
        for (int n = 0; n < 800; n++) begin
            logic [31:0] pick [4];
            pick[0] = 32'd0;
            pick[1] = 32'hFFFF_FFFF;
            pick[2] = 32'd1;
            pick[3] = $urandom;
            drive(($urandom_range(0, 49) != 0),
                  1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 12)),
                  8'($urandom_range(0, 13)),
                  ($urandom_range(0, 2) == 0) ? 9'd0 : 9'($urandom_range(0, 511)),
                  pick[$urandom_range(0, 3)],
                  pick[$urandom_range(0, 3)]);
            tick();
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
